// File: rtl/mc_fifoctl_pkg.sv
// Shared helpers for the multi-channel FIFO controller: width derivation
// and error-mode encodings.
package mc_fifoctl_pkg;

  localparam int ERR_STICKY = 0;
  localparam int ERR_DYN    = 1;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int max1(input int n);
    return (n < 1) ? 1 : n;
  endfunction

  function automatic int ch_w_f(input int num_ch);
    return max1(clog2(num_ch));
  endfunction

  function automatic int ptr_w_f(input int depth);
    return max1(clog2(depth));
  endfunction

  function automatic int cnt_w_f(input int depth);
    return clog2(depth + 1);
  endfunction

  function automatic int addr_w_f(input int num_ch, input int depth);
    return max1(clog2(num_ch * depth));
  endfunction

endpackage

// File: rtl/mc_fifoctl_ch.sv
// One channel of the FIFO controller: pointers, occupancy, registered
// flags and error state. Flags are derived from next-state count.
module mc_fifoctl_ch
  import mc_fifoctl_pkg::*;
#(
  parameter int depth    = 8,
  parameter int err_mode = ERR_STICKY,
  parameter int ptr_w    = 3,
  parameter int cnt_w    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_acc,
  input  logic             pop_acc,
  input  logic             push_req_err,
  input  logic             pop_req_err,
  input  logic             clr,
  input  logic [cnt_w-1:0] ae_level,
  input  logic [cnt_w-1:0] af_level,
  output logic [ptr_w-1:0] wptr,
  output logic [ptr_w-1:0] rptr,
  output logic [cnt_w-1:0] cnt,
  output logic             empty,
  output logic             almost_empty,
  output logic             half_full,
  output logic             almost_full,
  output logic             full,
  output logic             error
);

  localparam logic [ptr_w-1:0] PTR_LAST = ptr_w'(depth - 1);
  localparam logic [cnt_w-1:0] CNT_MAX  = cnt_w'(depth);
  localparam logic [cnt_w-1:0] CNT_HALF = cnt_w'((depth + 1) / 2);
  localparam logic [cnt_w:0]   DEPTH_X  = (cnt_w + 1)'(depth);

  logic [cnt_w-1:0] cnt_nxt;
  logic [cnt_w:0]   af_sum;
  logic             err_nxt;

  // Next count; almost_full tested as cnt+af >= depth so af > depth saturates high.
  always_comb begin
    cnt_nxt = cnt;
    if (push_acc && !pop_acc)      cnt_nxt = cnt + cnt_w'(1);
    else if (pop_acc && !push_acc) cnt_nxt = cnt - cnt_w'(1);
    af_sum  = {1'b0, cnt_nxt} + {1'b0, af_level};
    err_nxt = (err_mode == ERR_DYN) ? 1'b0 : error;
    err_nxt = err_nxt | push_req_err | pop_req_err;
  end

  // Channel state; reset and clr both return everything to the empty state.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wptr         <= '0;
      rptr         <= '0;
      cnt          <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      half_full    <= 1'b0;
      almost_full  <= 1'b0;
      full         <= 1'b0;
      error        <= 1'b0;
    end else begin
      if (push_acc) wptr <= (wptr == PTR_LAST) ? '0 : wptr + ptr_w'(1);
      if (pop_acc)  rptr <= (rptr == PTR_LAST) ? '0 : rptr + ptr_w'(1);
      cnt          <= cnt_nxt;
      empty        <= (cnt_nxt == '0);
      almost_empty <= (cnt_nxt <= ae_level);
      half_full    <= (cnt_nxt >= CNT_HALF);
      almost_full  <= (af_sum >= DEPTH_X);
      full         <= (cnt_nxt == CNT_MAX);
      error        <= err_nxt;
    end
  end

endmodule

// File: rtl/mc_fifoctl_s1_df.sv
// Multi-channel FIFO controller over one shared RAM. Decodes and accepts
// push/pop requests, generates RAM addresses and muxes per-channel state.
module mc_fifoctl_s1_df
  import mc_fifoctl_pkg::*;
#(
  parameter int num_ch   = 4,
  parameter int depth    = 8,
  parameter int err_mode = ERR_STICKY,
  localparam int ch_w    = ch_w_f(num_ch),
  localparam int ptr_w   = ptr_w_f(depth),
  localparam int cnt_w   = cnt_w_f(depth),
  localparam int addr_w  = addr_w_f(num_ch, depth)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_n,
  input  logic [ch_w-1:0]   push_ch,
  input  logic              pop_n,
  input  logic [ch_w-1:0]   pop_ch,
  input  logic [num_ch-1:0] clr,
  input  logic [cnt_w-1:0]  ae_level,
  input  logic [cnt_w-1:0]  af_level,
  input  logic [ch_w-1:0]   cnt_sel,
  output logic              wr_en_n,
  output logic [addr_w-1:0] wr_addr,
  output logic              rd_en_n,
  output logic [addr_w-1:0] rd_addr,
  output logic [cnt_w-1:0]  word_cnt,
  output logic [num_ch-1:0] empty,
  output logic [num_ch-1:0] almost_empty,
  output logic [num_ch-1:0] half_full,
  output logic [num_ch-1:0] almost_full,
  output logic [num_ch-1:0] full,
  output logic [num_ch-1:0] error,
  output logic              bad_ch
);

  // Channel-indexed views padded to the full index range so that an
  // out-of-range channel number reads as invalid / zero.
  localparam int ch_p = 2 ** ch_w;

  logic [ch_p-1:0]              ch_ok, clr_x, empty_x, full_x;
  logic [ch_p-1:0][cnt_w-1:0]   cnt_x;
  logic [ch_p-1:0][addr_w-1:0]  waddr_x, raddr_x;
  logic [num_ch-1:0][ptr_w-1:0] wptr, rptr;
  logic [num_ch-1:0][cnt_w-1:0] cnt;

  logic push_acc, pop_acc, same_ch, push_err, pop_err, bad_req;

  for (genvar g = 0; g < ch_p; g++) begin : gen_map
    if (g < num_ch) begin : gen_live
      assign ch_ok[g]   = 1'b1;
      assign clr_x[g]   = clr[g];
      assign empty_x[g] = empty[g];
      assign full_x[g]  = full[g];
      assign cnt_x[g]   = cnt[g];
      // Base is an elaboration-time constant; only an adder remains in logic.
      assign waddr_x[g] = addr_w'(g * depth) + addr_w'(wptr[g]);
      assign raddr_x[g] = addr_w'(g * depth) + addr_w'(rptr[g]);
    end else begin : gen_pad
      assign ch_ok[g]   = 1'b0;
      assign clr_x[g]   = 1'b0;
      assign empty_x[g] = 1'b0;
      assign full_x[g]  = 1'b0;
      assign cnt_x[g]   = '0;
      assign waddr_x[g] = '0;
      assign raddr_x[g] = '0;
    end
  end

  // Request acceptance; pop is resolved first since push-on-full depends on it.
  always_comb begin
    pop_acc  = rst_n && !pop_n && ch_ok[pop_ch] && !clr_x[pop_ch] && !empty_x[pop_ch];
    same_ch  = pop_acc && (pop_ch == push_ch);
    push_acc = rst_n && !push_n && ch_ok[push_ch] && !clr_x[push_ch] &&
               (!full_x[push_ch] || same_ch);
    push_err = rst_n && !push_n && ch_ok[push_ch] && !clr_x[push_ch] &&
               full_x[push_ch] && !same_ch;
    pop_err  = rst_n && !pop_n && ch_ok[pop_ch] && !clr_x[pop_ch] && empty_x[pop_ch];
    bad_req  = (!push_n && !ch_ok[push_ch]) || (!pop_n && !ch_ok[pop_ch]);
  end

  assign wr_en_n  = !push_acc;
  assign rd_en_n  = !pop_acc;
  assign wr_addr  = waddr_x[push_ch];
  assign rd_addr  = raddr_x[pop_ch];
  assign word_cnt = cnt_x[cnt_sel];

  for (genvar g = 0; g < num_ch; g++) begin : gen_ch
    mc_fifoctl_ch #(
      .depth(depth), .err_mode(err_mode), .ptr_w(ptr_w), .cnt_w(cnt_w)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_acc    (push_acc && (push_ch == ch_w'(g))),
      .pop_acc     (pop_acc  && (pop_ch  == ch_w'(g))),
      .push_req_err(push_err && (push_ch == ch_w'(g))),
      .pop_req_err (pop_err  && (pop_ch  == ch_w'(g))),
      .clr         (clr[g]),
      .ae_level    (ae_level),
      .af_level    (af_level),
      .wptr        (wptr[g]),
      .rptr        (rptr[g]),
      .cnt         (cnt[g]),
      .empty       (empty[g]),
      .almost_empty(almost_empty[g]),
      .half_full   (half_full[g]),
      .almost_full (almost_full[g]),
      .full        (full[g]),
      .error       (error[g])
    );
  end

  // Invalid-channel flag: set by any out-of-range request, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n)       bad_ch <= 1'b0;
    else if (bad_req) bad_ch <= 1'b1;
  end

endmodule

// File: tb/tb_mc_fifoctl_s1_df.sv
// Directed bench: a 4x8 sticky instance, plus a 3x5 pair (sticky and
// per-cycle error) driven with identical stimulus.
module tb_mc_fifoctl_s1_df;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Instance A: num_ch=4, depth=8, sticky errors
  logic       a_rst_n, a_push_n, a_pop_n;
  logic [1:0] a_push_ch, a_pop_ch, a_cnt_sel;
  logic [3:0] a_clr, a_ae, a_af;
  logic       a_wr_en_n, a_rd_en_n, a_bad;
  logic [4:0] a_wr_addr, a_rd_addr;
  logic [3:0] a_word_cnt, a_empty, a_aef, a_hf, a_aff, a_full, a_err;

  mc_fifoctl_s1_df #(.num_ch(4), .depth(8), .err_mode(0)) u_a (
    .clk(clk), .rst_n(a_rst_n), .push_n(a_push_n), .push_ch(a_push_ch),
    .pop_n(a_pop_n), .pop_ch(a_pop_ch), .clr(a_clr), .ae_level(a_ae),
    .af_level(a_af), .cnt_sel(a_cnt_sel), .wr_en_n(a_wr_en_n), .wr_addr(a_wr_addr),
    .rd_en_n(a_rd_en_n), .rd_addr(a_rd_addr), .word_cnt(a_word_cnt), .empty(a_empty),
    .almost_empty(a_aef), .half_full(a_hf), .almost_full(a_aff), .full(a_full),
    .error(a_err), .bad_ch(a_bad));

  // Instances S (sticky) and D (per-cycle): num_ch=3, depth=5
  logic       b_rst_n, b_push_n, b_pop_n;
  logic [1:0] b_push_ch, b_pop_ch, b_cnt_sel;
  logic [2:0] b_clr, b_ae, b_af;
  logic       s_wr_en_n, s_rd_en_n, s_bad, d_wr_en_n, d_rd_en_n, d_bad;
  logic [3:0] s_wr_addr, s_rd_addr, d_wr_addr, d_rd_addr;
  logic [2:0] s_word_cnt, s_empty, s_aef, s_hf, s_aff, s_full, s_err;
  logic [2:0] d_word_cnt, d_empty, d_aef, d_hf, d_aff, d_full, d_err;

  mc_fifoctl_s1_df #(.num_ch(3), .depth(5), .err_mode(0)) u_s (
    .clk(clk), .rst_n(b_rst_n), .push_n(b_push_n), .push_ch(b_push_ch),
    .pop_n(b_pop_n), .pop_ch(b_pop_ch), .clr(b_clr), .ae_level(b_ae),
    .af_level(b_af), .cnt_sel(b_cnt_sel), .wr_en_n(s_wr_en_n), .wr_addr(s_wr_addr),
    .rd_en_n(s_rd_en_n), .rd_addr(s_rd_addr), .word_cnt(s_word_cnt), .empty(s_empty),
    .almost_empty(s_aef), .half_full(s_hf), .almost_full(s_aff), .full(s_full),
    .error(s_err), .bad_ch(s_bad));

  mc_fifoctl_s1_df #(.num_ch(3), .depth(5), .err_mode(1)) u_d (
    .clk(clk), .rst_n(b_rst_n), .push_n(b_push_n), .push_ch(b_push_ch),
    .pop_n(b_pop_n), .pop_ch(b_pop_ch), .clr(b_clr), .ae_level(b_ae),
    .af_level(b_af), .cnt_sel(b_cnt_sel), .wr_en_n(d_wr_en_n), .wr_addr(d_wr_addr),
    .rd_en_n(d_rd_en_n), .rd_addr(d_rd_addr), .word_cnt(d_word_cnt), .empty(d_empty),
    .almost_empty(d_aef), .half_full(d_hf), .almost_full(d_aff), .full(d_full),
    .error(d_err), .bad_ch(d_bad));

  task automatic push_a(input logic [1:0] ch, input int exp_addr, input string tag);
    a_push_n  = 1'b0;
    a_push_ch = ch;
    #1 chk(tag, a_wr_addr, exp_addr);
    step();
    a_push_n = 1'b1;
  endtask

  int ops [9] = '{1, 1, 1, 2, 1, 1, 2, 1, 1};
  int np, nq, ecnt;

  initial begin
    a_rst_n = 1'b0; a_push_n = 1'b1; a_pop_n = 1'b1; a_push_ch = '0; a_pop_ch = '0;
    a_cnt_sel = '0; a_clr = '0; a_ae = '0; a_af = '0;
    b_rst_n = 1'b0; b_push_n = 1'b1; b_pop_n = 1'b1; b_push_ch = '0; b_pop_ch = '0;
    b_cnt_sel = '0; b_clr = '0; b_ae = '0; b_af = '0;

    // ---- A: reset state, a push held during reset must not write
    a_push_n = 1'b0; a_push_ch = 2'd2; a_cnt_sel = 2'd2;
    step();
    chk("rst_wr_en_n", a_wr_en_n, 1);
    chk("rst_empty", a_empty, 4'hF);
    chk("rst_aempty", a_aef, 4'hF);
    chk("rst_hf", a_hf, 0);
    chk("rst_afull", a_aff, 0);
    chk("rst_full", a_full, 0);
    chk("rst_err", a_err, 0);
    chk("rst_bad", a_bad, 0);
    chk("rst_cnt", a_word_cnt, 0);
    a_rst_n = 1'b1; a_push_n = 1'b1; a_ae = 4'd1; a_af = 4'd2;

    // ---- A: fill channel 2 (base 16)
    for (int i = 0; i < 8; i++) begin
      a_push_n = 1'b0; a_push_ch = 2'd2;
      #1;
      chk("fill_wr_en_n", a_wr_en_n, 0);
      chk("fill_wr_addr", a_wr_addr, 16 + i);
      step();
      a_push_n = 1'b1;
      chk("fill_cnt", a_word_cnt, i + 1);
      chk("fill_afull", a_aff[2], (i + 1 >= 6));
      chk("fill_hf", a_hf[2], (i + 1 >= 4));
      chk("fill_aempty", a_aef[2], (i + 1 <= 1));
      chk("fill_full", a_full[2], (i + 1 == 8));
    end
    chk("fill_empty_vec", a_empty, 4'b1011);

    // ---- A: push+pop on a full channel, both accepted, pointers wrap
    a_push_n = 1'b0; a_push_ch = 2'd2; a_pop_n = 1'b0; a_pop_ch = 2'd2;
    #1;
    chk("pp_wr_en_n", a_wr_en_n, 0);
    chk("pp_rd_en_n", a_rd_en_n, 0);
    chk("pp_wr_addr", a_wr_addr, 16);
    chk("pp_rd_addr", a_rd_addr, 16);
    step();
    a_push_n = 1'b1; a_pop_n = 1'b1;
    chk("pp_cnt", a_word_cnt, 8);
    chk("pp_err", a_err[2], 0);
    chk("pp_full", a_full[2], 1);

    // ---- A: overflow, sticky error, then clr
    a_push_n = 1'b0; a_push_ch = 2'd2;
    #1 chk("ovf_wr_en_n", a_wr_en_n, 1);
    step();
    a_push_n = 1'b1;
    chk("ovf_err", a_err[2], 1);
    chk("ovf_cnt", a_word_cnt, 8);
    step();
    chk("ovf_sticky", a_err[2], 1);
    a_clr = 4'b0100;
    step();
    a_clr = '0;
    chk("clr2_err", a_err[2], 0);
    chk("clr2_cnt", a_word_cnt, 0);
    chk("clr2_empty", a_empty[2], 1);
    chk("clr2_full", a_full[2], 0);

    // ---- A: pop empty ch0 with push ch0, no fall-through
    a_push_n = 1'b0; a_push_ch = 2'd0; a_pop_n = 1'b0; a_pop_ch = 2'd0;
    #1;
    chk("pe_rd_en_n", a_rd_en_n, 1);
    chk("pe_wr_en_n", a_wr_en_n, 0);
    chk("pe_wr_addr", a_wr_addr, 0);
    step();
    a_push_n = 1'b1; a_pop_n = 1'b1; a_cnt_sel = 2'd0;
    #1;
    chk("pe_err", a_err[0], 1);
    chk("pe_cnt", a_word_cnt, 1);

    // ---- A: clr with concurrent push; other channels keep state
    push_a(2'd1, 8, "c1_addr");
    push_a(2'd1, 9, "c1_addr");
    for (int i = 0; i < 4; i++) push_a(2'd3, 24 + i, "c3_addr");
    a_cnt_sel = 2'd3;
    #1 chk("c3_cnt", a_word_cnt, 4);
    a_clr = 4'b1000; a_push_n = 1'b0; a_push_ch = 2'd3;
    #1 chk("clr3_wr_en_n", a_wr_en_n, 1);
    step();
    a_clr = '0; a_push_n = 1'b1;
    chk("clr3_cnt", a_word_cnt, 0);
    chk("clr3_empty", a_empty[3], 1);
    chk("clr3_err", a_err[3], 0);
    a_cnt_sel = 2'd1;
    #1;
    chk("clr3_c1_cnt", a_word_cnt, 2);
    chk("clr3_c0_err", a_err[0], 1);

    // ---- A: af_level beyond depth saturates almost_full high everywhere
    a_af = 4'd15;
    step();
    chk("afsat", a_aff, 4'hF);

    // ---- A: reset mid-operation discards contents
    a_rst_n = 1'b0;
    step();
    a_rst_n = 1'b1; a_af = 4'd2;
    chk("mrst_empty", a_empty, 4'hF);
    chk("mrst_afull", a_aff, 0);
    chk("mrst_err", a_err, 0);
    chk("mrst_cnt", a_word_cnt, 0);

    // ---- B: depth 5, ch1 base 5, interleaved pushes and pops
    step();
    b_rst_n = 1'b1; b_cnt_sel = 2'd1;
    np = 0; nq = 0; ecnt = 0;
    for (int i = 0; i < 9; i++) begin
      if (ops[i] == 1) begin
        b_push_n = 1'b0; b_push_ch = 2'd1;
        #1;
        chk("b_wr_en_n", s_wr_en_n, 0);
        chk("b_wr_addr", s_wr_addr, 5 + (np % 5));
        np++; ecnt++;
      end else begin
        b_pop_n = 1'b0; b_pop_ch = 2'd1;
        #1;
        chk("b_rd_en_n", s_rd_en_n, 0);
        chk("b_rd_addr", s_rd_addr, 5 + nq);
        nq++; ecnt--;
      end
      step();
      b_push_n = 1'b1; b_pop_n = 1'b1;
      chk("b_cnt", s_word_cnt, ecnt);
    end
    chk("b_full_s", s_full[1], 1);
    chk("b_full_d", d_full[1], 1);

    // ---- B: overflow -> sticky vs single-cycle error
    b_push_n = 1'b0; b_push_ch = 2'd1;
    #1 chk("b_ovf_wr_en_n", d_wr_en_n, 1);
    step();
    b_push_n = 1'b1;
    chk("b_ovf_err_s", s_err[1], 1);
    chk("b_ovf_err_d", d_err[1], 1);
    step();
    chk("b_hold_err_s", s_err[1], 1);
    chk("b_hold_err_d", d_err[1], 0);
    b_clr = 3'b010;
    step();
    b_clr = '0;
    chk("b_clr_err_s", s_err[1], 0);
    chk("b_clr_cnt", s_word_cnt, 0);
    chk("b_clr_empty", s_empty, 3'b111);

    // ---- B: invalid channel
    b_push_n = 1'b0; b_push_ch = 2'd3;
    #1 chk("bad_wr_en_n", s_wr_en_n, 1);
    step();
    b_push_n = 1'b1;
    chk("bad_set", s_bad, 1);
    chk("bad_nostate", s_empty, 3'b111);
    step();
    step();
    chk("bad_hold", s_bad, 1);
    b_cnt_sel = 2'd3;
    #1 chk("bad_cnt_sel", s_word_cnt, 0);
    b_rst_n = 1'b0;
    step();
    chk("bad_rst", s_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
